// File: rtl/ps2_cursor_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_cursor_tracker: PS/2 mouse packets -> clamped cursor, buttons, wheel |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ps2_cursor_tracker #(
    parameter int COORD_W  = 16,
    parameter int X_MAX    = 639,
    parameter int Y_MAX    = 479,
    parameter int X_INIT   = 320,
    parameter int Y_INIT   = 240,
    parameter bit WHEEL_EN = 1'b1,
    parameter int TIMEOUT  = 50000
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               mode4,
    input  logic [1:0]         speed,
    input  logic               recenter,
    output logic [COORD_W-1:0] cursor_x,
    output logic [COORD_W-1:0] cursor_y,
    output logic [2:0]         buttons,
    output logic [7:0]         wheel,
    output logic               pkt_valid,
    output logic               sync_err,
    output logic [7:0]         err_count
);

    localparam int SW = COORD_W + 4;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic signed [SW-1:0] c_x_max = SW'(X_MAX);
    localparam logic signed [SW-1:0] c_y_max = SW'(Y_MAX);

    typedef enum logic [1:0] {B0 = 2'd0, B1 = 2'd1, B2 = 2'd2, B3 = 2'd3} state_t;

    state_t r_state, w_state_nxt;
    logic [3:0]    r_hdr;      // {y_ovf, x_ovf, y_sign, x_sign}
    logic [2:0]    r_btn;
    logic [7:0]    r_b1, r_b2;
    logic [TW-1:0] r_tmo;

    logic       w_hdr_err, w_timeout, w_commit, w_is4, w_tmo_hit;
    logic [7:0] w_dy_byte;
    logic [3:0] w_z;

    assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_hdr_err   = 1'b0;
        w_timeout   = 1'b0;
        w_commit    = 1'b0;
        w_is4       = 1'b0;
        w_dy_byte   = r_b2;
        w_z         = 4'd0;
        case (r_state)
            B0: if (rx_valid) begin
                if (rx_data[3]) w_state_nxt = B1;
                else            w_hdr_err   = 1'b1;
            end
            B1: if (rx_valid) w_state_nxt = B2;
            B2: if (rx_valid) begin
                if (mode4 && WHEEL_EN) begin
                    w_state_nxt = B3;
                end else begin
                    w_state_nxt = B0;
                    w_commit    = 1'b1;
                    w_dy_byte   = rx_data;
                end
            end
            default: if (rx_valid) begin
                w_state_nxt = B0;
                w_commit    = 1'b1;
                w_is4       = 1'b1;
                w_z         = rx_data[3:0];
            end
        endcase
        if (r_state != B0 && !rx_valid && w_tmo_hit) begin
            w_state_nxt = B0;
            w_timeout   = 1'b1;
        end
    end

    // 9-bit delta; a set overflow bit pins it to the extreme of its sign
    function automatic logic [8:0] delta9(input logic sgn, input logic ovf,
                                          input logic [7:0] mag);
        if (ovf) return sgn ? 9'h100 : 9'h0FF;
        return {sgn, mag};
    endfunction

    logic [8:0]           w_dx9, w_dy9;
    logic signed [SW-1:0] w_dx, w_dy, w_x_sum, w_y_sum;
    logic [COORD_W-1:0]   w_x_new, w_y_new;
    logic [8:0]           w_w_sum;
    logic [7:0]           w_w_new;

    always_comb begin
        w_dx9   = delta9(r_hdr[0], r_hdr[2], r_b1);
        w_dy9   = delta9(r_hdr[1], r_hdr[3], w_dy_byte);
        w_dx    = $signed({{(SW-9){w_dx9[8]}}, w_dx9}) <<< speed;
        w_dy    = $signed({{(SW-9){w_dy9[8]}}, w_dy9}) <<< speed;
        w_x_sum = $signed({4'b0, cursor_x}) + w_dx;
        w_y_sum = $signed({4'b0, cursor_y}) - w_dy;

        if (w_x_sum[SW-1])         w_x_new = '0;
        else if (w_x_sum > c_x_max) w_x_new = COORD_W'(X_MAX);
        else                       w_x_new = w_x_sum[COORD_W-1:0];

        if (w_y_sum[SW-1])         w_y_new = '0;
        else if (w_y_sum > c_y_max) w_y_new = COORD_W'(Y_MAX);
        else                       w_y_new = w_y_sum[COORD_W-1:0];

        w_w_sum = {wheel[7], wheel} + {{5{w_z[3]}}, w_z};
        if (w_w_sum[8] != w_w_sum[7]) w_w_new = w_w_sum[8] ? 8'h80 : 8'h7F;
        else                          w_w_new = w_w_sum[7:0];
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state   <= B0;
            r_hdr     <= '0;
            r_btn     <= '0;
            r_b1      <= '0;
            r_b2      <= '0;
            r_tmo     <= '0;
            cursor_x  <= COORD_W'(X_INIT);
            cursor_y  <= COORD_W'(Y_INIT);
            buttons   <= '0;
            wheel     <= '0;
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
            err_count <= '0;
        end else begin
            r_state   <= w_state_nxt;
            pkt_valid <= w_commit;
            sync_err  <= w_hdr_err | w_timeout;

            if (rx_valid) begin
                case (r_state)
                    B0: if (rx_data[3]) begin
                        r_hdr <= rx_data[7:4];
                        r_btn <= rx_data[2:0];
                    end
                    B1: r_b1 <= rx_data;
                    B2: r_b2 <= rx_data;
                    default: ;
                endcase
            end

            if (w_state_nxt == B0 || rx_valid) r_tmo <= '0;
            else                               r_tmo <= r_tmo + TW'(1);

            if ((w_hdr_err | w_timeout) && err_count != 8'hFF)
                err_count <= err_count + 8'd1;

            if (w_commit) buttons <= r_btn;

            if (recenter) begin
                cursor_x <= COORD_W'(X_INIT);
                cursor_y <= COORD_W'(Y_INIT);
                wheel    <= '0;
            end else if (w_commit) begin
                cursor_x <= w_x_new;
                cursor_y <= w_y_new;
                if (w_is4) wheel <= w_w_new;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_cursor_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ps2_cursor_tracker: directed + randomized checks against a model      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ps2_cursor_tracker;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid, mode4, recenter;
    logic [1:0]  speed;
    logic [15:0] cursor_x, cursor_y;
    logic [2:0]  buttons;
    logic [7:0]  wheel, err_count;
    logic        pkt_valid, sync_err;

    ps2_cursor_tracker #(.TIMEOUT(TMO)) dut (
        .clk_clk(clk), .reset_reset(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .mode4(mode4), .speed(speed), .recenter(recenter),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .buttons(buttons), .wheel(wheel),
        .pkt_valid(pkt_valid), .sync_err(sync_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    int mx = 320, my = 240, mw = 0, mbtn = 0, merr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int delta(input int sgn, input int ovf, input int mag);
        if (ovf != 0) return (sgn != 0) ? -256 : 255;
        return (sgn != 0) ? mag - 256 : mag;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_pkt(input int b0, input int b1, input int b2, input int z,
                             input bit is4, input int sp, input bit rc);
        int dx, dy;
        dx = delta((b0 >> 4) & 1, (b0 >> 6) & 1, b1) * (1 << sp);
        dy = delta((b0 >> 5) & 1, (b0 >> 7) & 1, b2) * (1 << sp);
        mx = clampi(mx + dx, 0, 639);
        my = clampi(my - dy, 0, 479);
        if (is4) mw = clampi(mw + ((z >= 8) ? z - 16 : z), -128, 127);
        mbtn = b0 & 7;
        if (rc) begin mx = 320; my = 240; mw = 0; end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".x"}, 32'(cursor_x), mx);
        chk({tag, ".y"}, 32'(cursor_y), my);
        chk({tag, ".btn"}, 32'(buttons), mbtn);
        chk({tag, ".wheel"}, 32'($signed(wheel)), mw);
        chk({tag, ".errs"}, 32'(err_count), merr);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic packet(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3, input bit is4,
                          input bit rc);
        mode4 = 1'b0;
        send(b0);
        send(b1);
        mode4 = is4;
        recenter = rc && !is4;
        send(b2);
        if (is4) begin
            mode4 = 1'b0;
            recenter = rc;
            send(b3);
        end
        recenter = 1'b0;
        mode4 = 1'b0;
        model_pkt(int'(b0), int'(b1), int'(b2), int'(b3[3:0]), is4, int'(speed), rc);
        chk({tag, ".pkt_valid"}, 32'(pkt_valid), 1);
        check_outputs(tag);
    endtask

    initial begin
        int k;
        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; mode4 = 1'b0;
        speed = 2'd0; recenter = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset.pkt_valid", 32'(pkt_valid), 0);
        chk("reset.sync_err", 32'(sync_err), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic 3-byte packet
        packet("t1", 8'h08, 8'h05, 8'h03, 8'h00, 1'b0, 1'b0);
        chk("t1.abs_x", 32'(cursor_x), 325);
        chk("t1.abs_y", 32'(cursor_y), 237);
        @(posedge clk); #1;
        chk("t1.pulse_end", 32'(pkt_valid), 0);

        // Negative dx with gain, after a standalone recenter
        recenter = 1'b1; @(posedge clk); #1; recenter = 1'b0;
        mx = 320; my = 240; mw = 0;
        chk("recenter.x", 32'(cursor_x), 320);
        speed = 2'd2;
        packet("t2", 8'h19, 8'hF6, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("t2.abs_x", 32'(cursor_x), 280);

        // Overflow handling and clamping
        packet("t3a", 8'h48, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("t3a.clamp_x", 32'(cursor_x), 639);
        speed = 2'd0;
        packet("t3b", 8'h38, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("t3b.abs_x", 32'(cursor_x), 383);
        chk("t3b.clamp_y", 32'(cursor_y), 479);

        // Bad header
        send(8'h00);
        merr++;
        chk("t4.sync_err", 32'(sync_err), 1);
        chk("t4.no_pkt", 32'(pkt_valid), 0);
        chk("t4.errs", 32'(err_count), 1);
        packet("t4b", 8'h08, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0);

        // Wheel saturation
        for (int i = 0; i < 20; i++)
            packet("t5", 8'h08, 8'h00, 8'h00, 8'h07, 1'b1, 1'b0);
        chk("t5.wheel_sat", 32'($signed(wheel)), 127);
        packet("t5b", 8'h08, 8'h00, 8'h00, 8'h0F, 1'b1, 1'b0);
        chk("t5b.wheel", 32'($signed(wheel)), 126);

        // Timeout mid-packet
        send(8'h08);
        send(8'h01);
        k = 0;
        while (k < TMO + 8) begin
            @(posedge clk); #1;
            k++;
            if (sync_err) break;
        end
        merr++;
        chk("t6.tmo_cycles", 32'(k), TMO);
        check_outputs("t6.tmo");
        packet("t6.recenter", 8'h0B, 8'h10, 8'h10, 8'h00, 1'b0, 1'b1);

        // Randomized packets, occasional bad headers
        for (int i = 0; i < 60; i++) begin
            speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                send(8'($urandom) & 8'hF7);
                merr++;
                chk("rnd.sync_err", 32'(sync_err), 1);
                chk("rnd.errs", 32'(err_count), merr);
            end else begin
                packet("rnd", 8'($urandom) | 8'h08, 8'($urandom), 8'($urandom),
                       8'($urandom), 1'($urandom), $urandom_range(0, 9) == 0);
            end
        end

        // Asynchronous reset mid-packet
        speed = 2'd0;
        packet("pre_rst", 8'h08, 8'h07, 8'h00, 8'h00, 1'b0, 1'b0);
        send(8'h08);
        send(8'h01);
        #2 rst = 1'b1;
        #1;
        mx = 320; my = 240; mw = 0; mbtn = 0; merr = 0;
        check_outputs("async_rst");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        packet("post_rst", 8'h09, 8'h02, 8'h02, 8'h00, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
